asrv32_regfile_ctrl: RTL and testbench



---
 rtl/asrv32_regfile_ctrl.sv | 139 +++++++++++++
 tb/tb_asrv32_regfile_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/asrv32_regfile_ctrl.sv
// Register-file controller: writeback arbitration, write-port register stage, per-register busy scoreboard.
// Optional macro ASRV32_REGFILE_CTRL_RR_EN selects round-robin arbitration instead of fixed priority.
module asrv32_regfile_ctrl #(
  parameter int NUM_REQ = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [5*NUM_REQ-1:0]  i_req_rd,
  input  logic [32*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]    o_req_ready,
  input  logic                  i_issue_valid,
  input  logic [4:0]            i_issue_rd,
  output logic                  o_issue_ready,
  input  logic                  i_rd_req,
  input  logic [4:0]            i_rs1_addr,
  input  logic [4:0]            i_rs2_addr,
  output logic                  o_rd_stall,
  output logic                  o_ce_rd,
  output logic                  o_ce_wr,
  output logic [4:0]            o_rd_addr,
  output logic [31:0]           o_rd_data,
  input  logic                  i_flush,
  output logic                  o_sb_err
);

  logic [31:0] busy_q, busy_d;
  logic        ce_wr_q, ce_wr_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        sb_err_q, sb_err_d;

  logic        found;
  int          win_idx;
  logic        hs;
  logic        wr_en;
  logic [4:0]  win_rd;
  logic [31:0] win_data;
  logic        haz1, haz2;

`ifdef ASRV32_REGFILE_CTRL_RR_EN
  logic [1:0] ptr_q, ptr_d;

  // Search starts at the pointer and wraps, so the last winner goes to the back of the line.
  always_comb begin
    found   = 1'b0;
    win_idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && i_req_valid[(int'(ptr_q) + i) % NUM_REQ]) begin
        found   = 1'b1;
        win_idx = (int'(ptr_q) + i) % NUM_REQ;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = 2'((win_idx + 1) % NUM_REQ);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ptr_q <= 2'd0;
    else          ptr_q <= ptr_d;
  end
`else
  always_comb begin
    found   = 1'b0;
    win_idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && i_req_valid[i]) begin
        found   = 1'b1;
        win_idx = i;
      end
    end
  end
`endif

  assign hs       = found & ~i_flush;
  assign win_rd   = i_req_rd[5*win_idx +: 5];
  assign win_data = i_req_data[32*win_idx +: 32];
  assign wr_en    = hs & (win_rd != 5'd0);

  always_comb begin
    o_req_ready = '0;
    if (hs) o_req_ready[win_idx] = 1'b1;
  end

  assign o_issue_ready = (i_issue_rd == 5'd0) | ~busy_q[i_issue_rd];

  // The registered write has not reached the regfile yet, so it still counts as a hazard.
  assign haz1 = (i_rs1_addr != 5'd0) &
                (busy_q[i_rs1_addr] | (ce_wr_q & (rd_addr_q == i_rs1_addr)));
  assign haz2 = (i_rs2_addr != 5'd0) &
                (busy_q[i_rs2_addr] | (ce_wr_q & (rd_addr_q == i_rs2_addr)));

  assign o_rd_stall = i_rd_req & (haz1 | haz2);
  assign o_ce_rd    = i_rd_req & ~o_rd_stall;

  always_comb begin
    ce_wr_d   = wr_en;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    sb_err_d  = sb_err_q;
    busy_d    = busy_q;
    if (wr_en) begin
      rd_addr_d      = win_rd;
      rd_data_d      = win_data;
      sb_err_d       = sb_err_q | ~busy_q[win_rd];
      busy_d[win_rd] = 1'b0;
    end
    if (i_flush)
      busy_d = '0;
    else if (i_issue_valid && o_issue_ready && (i_issue_rd != 5'd0))
      busy_d[i_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q    <= '0;
      ce_wr_q   <= 1'b0;
      rd_addr_q <= 5'd0;
      rd_data_q <= 32'd0;
      sb_err_q  <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      ce_wr_q   <= ce_wr_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      sb_err_q  <= sb_err_d;
    end
  end

  assign o_ce_wr   = ce_wr_q;
  assign o_rd_addr = rd_addr_q;
  assign o_rd_data = rd_data_q;
  assign o_sb_err  = sb_err_q;

endmodule

// File: tb/tb_asrv32_regfile_ctrl.sv
// Directed bench for asrv32_regfile_ctrl with a scoreboard-level reference model checked every cycle.
module tb_asrv32_regfile_ctrl;
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [5*N-1:0]  req_rd = '0;
  logic [32*N-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          issue_valid = 1'b0;
  logic [4:0]    issue_rd = '0;
  logic          issue_ready;
  logic          rd_req = 1'b0;
  logic [4:0]    rs1 = '0, rs2 = '0;
  logic          rd_stall, ce_rd, ce_wr, sb_err;
  logic [4:0]    rd_addr;
  logic [31:0]   rd_data;
  logic          flush = 1'b0;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  asrv32_regfile_ctrl #(.NUM_REQ(N)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_rd(req_rd), .i_req_data(req_data),
    .o_req_ready(req_ready),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd), .o_issue_ready(issue_ready),
    .i_rd_req(rd_req), .i_rs1_addr(rs1), .i_rs2_addr(rs2),
    .o_rd_stall(rd_stall), .o_ce_rd(ce_rd),
    .o_ce_wr(ce_wr), .o_rd_addr(rd_addr), .o_rd_data(rd_data),
    .i_flush(flush), .o_sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a set of busy registers plus the one pending regfile write.
  bit [31:0] m_busy;
  bit        m_ce;
  bit [4:0]  m_addr;
  bit [31:0] m_data;
  bit        m_err;
  int        m_ptr;

  function automatic int m_winner();
    if (flush) return -1;
    for (int i = 0; i < N; i++) begin
`ifdef ASRV32_REGFILE_CTRL_RR_EN
      if (req_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
`else
      if (req_valid[i]) return i;
`endif
    end
    return -1;
  endfunction

  function automatic bit m_hazard(input bit [4:0] s);
    if (s == 0) return 1'b0;
    return m_busy[s] || (m_ce && m_addr == s);
  endfunction

  function automatic bit m_issue_ok();
    return (issue_rd == 0) || !m_busy[issue_rd];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = '0; m_ce = 0; m_addr = 0; m_data = 0; m_err = 0; m_ptr = 0;
    end else begin
      int  w;
      bit  iss;
      bit [4:0] r;
      w   = m_winner();
      iss = issue_valid && m_issue_ok() && issue_rd != 0 && !flush;
      m_ce = 1'b0;
      if (w >= 0) begin
        r = req_rd[5*w +: 5];
        m_ptr = (w + 1) % N;
        if (r != 0) begin
          m_ce = 1'b1;
          m_addr = r;
          m_data = req_data[32*w +: 32];
          if (!m_busy[r]) m_err = 1'b1;
          m_busy[r] = 1'b0;
        end
      end
      if (flush) m_busy = '0;
      if (iss) m_busy[issue_rd] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int w;
      bit [N-1:0] er;
      bit stall;
      w = m_winner();
      er = '0;
      if (w >= 0) er[w] = 1'b1;
      stall = rd_req && (m_hazard(rs1) || m_hazard(rs2));
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("issue_ready", 32'(issue_ready), 32'(m_issue_ok()));
      chk("rd_stall", 32'(rd_stall), 32'(stall));
      chk("ce_rd", 32'(ce_rd), 32'(rd_req && !stall));
      chk("ce_wr", 32'(ce_wr), 32'(m_ce));
      chk("rd_addr", 32'(rd_addr), 32'(m_addr));
      chk("rd_data", rd_data, m_data);
      chk("sb_err", 32'(sb_err), 32'(m_err));
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int k, input bit v, input logic [4:0] r, input logic [31:0] d);
    req_valid[k] = v;
    req_rd[5*k +: 5] = r;
    req_data[32*k +: 32] = d;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) cyc();
    #2;
    chk("rst ce_wr", 32'(ce_wr), 32'd0);
    chk("rst rd_addr", 32'(rd_addr), 32'd0);
    chk("rst rd_data", rd_data, 32'd0);
    chk("rst sb_err", 32'(sb_err), 32'd0);
    chk("rst issue_ready", 32'(issue_ready), 32'd1);
    chk("rst ce_rd", 32'(ce_rd), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // RAW stall on x5 until the registered write has committed
    issue_valid = 1; issue_rd = 5; cyc();
    issue_valid = 0; rd_req = 1; rs1 = 5; rs2 = 0;
    set_req(0, 1, 5, 32'hDEADBEEF);
    #2;
    chk("raw stall", 32'(rd_stall), 32'd1);
    chk("raw ce_rd", 32'(ce_rd), 32'd0);
    chk("raw ready", 32'(req_ready), 32'b001);
    cyc();
    set_req(0, 0, 0, 0);
    #2;
    chk("wr ce_wr", 32'(ce_wr), 32'd1);
    chk("wr addr", 32'(rd_addr), 32'd5);
    chk("wr data", rd_data, 32'hDEADBEEF);
    chk("inflight stall", 32'(rd_stall), 32'd1);
    cyc();
    #2;
    chk("post stall", 32'(rd_stall), 32'd0);
    chk("post ce_rd", 32'(ce_rd), 32'd1);
    rd_req = 0;

    // Two simultaneous requesters
    issue_valid = 1; issue_rd = 3; cyc();
    issue_rd = 4; cyc();
    issue_valid = 0;
    set_req(0, 1, 3, 32'h33); set_req(2, 1, 4, 32'h44);
    #2;
`ifdef ASRV32_REGFILE_CTRL_RR_EN
    chk("arb first", 32'(req_ready), 32'b100);
    cyc(); set_req(2, 0, 0, 0); #2;
    chk("arb second", 32'(req_ready), 32'b001);
    cyc(); set_req(0, 0, 0, 0); #2;
    chk("arb last addr", 32'(rd_addr), 32'd3);
`else
    chk("arb first", 32'(req_ready), 32'b001);
    cyc(); set_req(0, 0, 0, 0); #2;
    chk("arb second", 32'(req_ready), 32'b100);
    cyc(); set_req(2, 0, 0, 0); #2;
    chk("arb last addr", 32'(rd_addr), 32'd4);
`endif
    chk("arb no err", 32'(sb_err), 32'd0);

    // WAW: back-to-back issue to x7 holds until the x7 write is accepted
    cyc();
    issue_valid = 1; issue_rd = 7; cyc();
    #2 chk("waw 1", 32'(issue_ready), 32'd0);
    cyc();
    set_req(1, 1, 7, 32'h77);
    #2;
    chk("waw 2", 32'(issue_ready), 32'd0);
    chk("waw wr ready", 32'(req_ready), 32'b010);
    cyc();
    set_req(1, 0, 0, 0);
    #2;
    chk("waw release", 32'(issue_ready), 32'd1);
    chk("waw wr addr", 32'(rd_addr), 32'd7);
    cyc();
    issue_valid = 0;

    // Write to x0, then an unexpected write to x9
    set_req(1, 1, 0, 32'hFFFFFFFF);
    #2 chk("x0 ready", 32'(req_ready), 32'b010);
    cyc();
    set_req(1, 0, 0, 0);
    #2;
    chk("x0 ce_wr", 32'(ce_wr), 32'd0);
    chk("x0 no err", 32'(sb_err), 32'd0);
    cyc();
    set_req(0, 1, 9, 32'h12345678);
    #2 chk("x9 ready", 32'(req_ready), 32'b001);
    cyc();
    set_req(0, 0, 0, 0);
    #2;
    chk("x9 err", 32'(sb_err), 32'd1);
    chk("x9 ce_wr", 32'(ce_wr), 32'd1);
    chk("x9 addr", 32'(rd_addr), 32'd9);
    chk("x9 data", rd_data, 32'h12345678);

    // Flush with a write in flight and a write request pending
    cyc();
    issue_valid = 1; issue_rd = 6; cyc();
    issue_rd = 8; cyc();
    issue_valid = 0;
    set_req(2, 1, 7, 32'hA7); cyc();
    set_req(2, 0, 0, 0);
    flush = 1; set_req(0, 1, 6, 32'h66);
    issue_valid = 1; issue_rd = 10;
    #2;
    chk("flush ready", 32'(req_ready), 32'b000);
    chk("flush inflight", 32'(ce_wr), 32'd1);
    chk("flush inflight addr", 32'(rd_addr), 32'd7);
    cyc();
    flush = 0; issue_valid = 0; issue_rd = 8;
    rd_req = 1; rs1 = 10; rs2 = 6;
    #2;
    chk("flush x8 ready", 32'(issue_ready), 32'd1);
    chk("flush no stall", 32'(rd_stall), 32'd0);
    chk("flush ce_wr", 32'(ce_wr), 32'd0);
    chk("after flush ready", 32'(req_ready), 32'b001);
    cyc();
    set_req(0, 0, 0, 0); rd_req = 0;
    #2 chk("after flush addr", 32'(rd_addr), 32'd6);

    // Asynchronous reset drops a pending write immediately
    cyc();
    set_req(1, 1, 12, 32'hC); cyc();
    set_req(1, 0, 0, 0);
    #2 chk("pre-rst ce_wr", 32'(ce_wr), 32'd1);
    rst_n = 0;
    #1;
    chk("async rst ce_wr", 32'(ce_wr), 32'd0);
    chk("async rst err", 32'(sb_err), 32'd0);
    chk("async rst addr", 32'(rd_addr), 32'd0);
    cyc();
    rst_n = 1;
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
